// File: rtl/lmi_lbc_rdq_if.sv
// Core-side and CBUS-side signal bundle for the data read-return queue.
// Master drives requests, return beats and DREADY; slave is the queue.
interface lmi_lbc_rdq_if #(
  parameter int DW = 32
);
  localparam int OFFW = $clog2(DW/8);

  logic            FLUSH;
  logic            REQ_VALID;
  logic            REQ_LINE;
  logic [1:0]      REQ_SZ;
  logic            REQ_SIGN;
  logic [OFFW-1:0] REQ_OFFSET;
  logic            REQ_READY;
  logic            CBUS_SDVAL;
  logic [DW-1:0]   CBUS_SDDATA;
  logic            DVALO;
  logic [DW-1:0]   DDATAO;
  logic            DLASTO;
  logic            DREADY;
  logic            OVERFLOW_R;

  modport master (
    output FLUSH, REQ_VALID, REQ_LINE, REQ_SZ, REQ_SIGN, REQ_OFFSET,
           CBUS_SDVAL, CBUS_SDDATA, DREADY,
    input  REQ_READY, DVALO, DDATAO, DLASTO, OVERFLOW_R
  );

  modport slave (
    input  FLUSH, REQ_VALID, REQ_LINE, REQ_SZ, REQ_SIGN, REQ_OFFSET,
           CBUS_SDVAL, CBUS_SDDATA, DREADY,
    output REQ_READY, DVALO, DDATAO, DLASTO, OVERFLOW_R
  );
endinterface

// File: rtl/lmi_lbc_rdq.sv
// Read-return queue: buffers CBUS beats per outstanding request, aligns/sign-extends to the core; 1 cycle min latency.
// Backpressure: DREADY stalls the head beat; beats with no owner or arriving to a full FIFO are dropped and flagged.
module lmi_lbc_rdq #(
  parameter int DW         = 32,
  parameter int DEPTH      = 4,
  parameter int OUTST      = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic         IDCLOCKI,
  input  logic         RESET_D1_R_N,
  lmi_lbc_rdq_if.slave bus
);
  localparam int OFFW = $clog2(DW/8);
  localparam int AAW  = $clog2(OUTST);
  localparam int DAW  = $clog2(DEPTH);
  localparam int CW   = $clog2(OUTST*LINE_WORDS) + 1;
  localparam int BW   = $clog2(LINE_WORDS);

  typedef struct packed {
    logic            line;
    logic [1:0]      sz;
    logic            sign;
    logic [OFFW-1:0] off;
  } attr_t;

  attr_t         attr_mem [OUTST];
  logic [DW-1:0] data_mem [DEPTH];

  logic [AAW:0]    a_wp, a_rp;
  logic [DAW:0]    d_wp, d_rp;
  logic [CW-1:0]   exp_cnt;
  logic [BW-1:0]   beat_cnt;
  logic            ovf;

  attr_t           head, req_attr;
  logic            a_full, d_empty, d_full;
  logic            req_acc, req_drop, beat_acc, beat_drop, pop, last;
  logic [CW-1:0]   exp_inc;
  logic [DW-1:0]   raw, aligned, sh, msk;
  logic [OFFW-1:0] eff;
  logic            top;

  assign req_attr = '{line: bus.REQ_LINE, sz: bus.REQ_SZ, sign: bus.REQ_SIGN, off: bus.REQ_OFFSET};
  assign head     = attr_mem[a_rp[AAW-1:0]];
  assign raw      = data_mem[d_rp[DAW-1:0]];

  assign a_full  = (a_wp[AAW] != a_rp[AAW]) && (a_wp[AAW-1:0] == a_rp[AAW-1:0]);
  assign d_full  = (d_wp[DAW] != d_rp[DAW]) && (d_wp[DAW-1:0] == d_rp[DAW-1:0]);
  assign d_empty = (d_wp == d_rp);

  assign pop  = !d_empty && bus.DREADY;
  assign last = !d_empty && (!head.line || beat_cnt == BW'(LINE_WORDS - 1));

  assign req_acc  = bus.REQ_VALID && !a_full && !bus.FLUSH;
  assign req_drop = bus.REQ_VALID &&  a_full && !bus.FLUSH;
  // A beat needs an owner (registered count only) and a slot, which a same-cycle pop provides.
  assign beat_acc  = bus.CBUS_SDVAL && !bus.FLUSH && (exp_cnt != '0) && (!d_full || pop);
  assign beat_drop = bus.CBUS_SDVAL && !bus.FLUSH && !beat_acc;

  assign exp_inc = req_acc ? (bus.REQ_LINE ? CW'(LINE_WORDS) : CW'(1)) : '0;

  always_ff @(posedge IDCLOCKI or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      a_wp     <= '0;
      a_rp     <= '0;
      d_wp     <= '0;
      d_rp     <= '0;
      exp_cnt  <= '0;
      beat_cnt <= '0;
      ovf      <= 1'b0;
    end else if (bus.FLUSH) begin
      a_wp     <= '0;
      a_rp     <= '0;
      d_wp     <= '0;
      d_rp     <= '0;
      exp_cnt  <= '0;
      beat_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (req_acc)  a_wp <= a_wp + 1'b1;
      if (beat_acc) d_wp <= d_wp + 1'b1;
      if (pop) begin
        d_rp <= d_rp + 1'b1;
        if (last) begin
          a_rp     <= a_rp + 1'b1;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      exp_cnt <= exp_cnt + exp_inc - CW'(beat_acc);
      if (req_drop || beat_drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge IDCLOCKI) begin
    if (req_acc)  attr_mem[a_wp[AAW-1:0]] <= req_attr;
    if (beat_acc) data_mem[d_wp[DAW-1:0]] <= bus.CBUS_SDDATA;
  end

  // Misaligned offsets are rounded down to the access size before shifting.
  always_comb begin
    eff = '0;
    if (head.sz != 2'b11) eff = head.off & ~OFFW'((1 << head.sz) - 1);
    sh = raw >> {eff, 3'b000};
    case (head.sz)
      2'b00:   begin msk = DW'(8'hFF);         top = sh[7];  end
      2'b01:   begin msk = DW'(16'hFFFF);      top = sh[15]; end
      2'b10:   begin msk = DW'(32'hFFFF_FFFF); top = sh[31]; end
      default: begin msk = '1;                 top = 1'b0;   end
    endcase
    aligned = (sh & msk) | ({DW{head.sign & top}} & ~msk);
  end

  assign bus.REQ_READY  = !a_full;
  assign bus.DVALO      = !d_empty;
  assign bus.DDATAO     = d_empty ? '0 : (head.line ? raw : aligned);
  assign bus.DLASTO     = last;
  assign bus.OVERFLOW_R = ovf;
endmodule

// File: tb/tb_lmi_lbc_rdq.sv
// Bench for lmi_lbc_rdq: queue-based reference model checked every cycle, directed scenarios with literal
// expectations, then randomized traffic with flushes.
module tb_lmi_lbc_rdq;
  localparam int DW = 32, DEPTH = 4, OUTST = 2, LW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lmi_lbc_rdq_if #(.DW(DW)) bus ();

  lmi_lbc_rdq #(.DW(DW), .DEPTH(DEPTH), .OUTST(OUTST), .LINE_WORDS(LW)) dut (
    .IDCLOCKI    (clk),
    .RESET_D1_R_N(rst_n),
    .bus         (bus)
  );

  typedef struct {
    logic       line;
    logic [1:0] sz;
    logic       sign;
    int         off;
  } attr_t;

  attr_t         aq[$];
  logic [DW-1:0] dq[$];
  int            expc, hidx;
  logic          movf;
  int            checks = 0, errs = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_align(logic [DW-1:0] raw, attr_t a);
    int nb, eff;
    logic [DW-1:0] v, mask;
    if (a.line) return raw;
    nb = (a.sz == 2'd3) ? DW/8 : (1 << a.sz);
    if (nb > DW/8) nb = DW/8;
    eff = a.off - (a.off % nb);
    v = raw >> (8*eff);
    if (nb == DW/8) return v;
    mask = (DW'(1) << (8*nb)) - DW'(1);
    v = v & mask;
    if (a.sign && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic m_last();
    if (dq.size() == 0 || aq.size() == 0) return 1'b0;
    return !aq[0].line || hidx == LW-1;
  endfunction

  function automatic logic [DW-1:0] m_data();
    if (dq.size() == 0) return '0;
    if (aq.size() == 0) return dq[0];
    return m_align(dq[0], aq[0]);
  endfunction

  task automatic model_reset();
    aq.delete();
    dq.delete();
    expc = 0;
    hidx = 0;
    movf = 1'b0;
  endtask

  task automatic model_step();
    logic dval, pop, plast, afull, dfull;
    int   e0;
    if (bus.FLUSH) begin
      model_reset();
      return;
    end
    dval  = dq.size() != 0;
    pop   = dval && bus.DREADY;
    plast = m_last();
    afull = aq.size() == OUTST;
    dfull = dq.size() == DEPTH;
    e0    = expc;
    if (bus.REQ_VALID) begin
      if (afull) movf = 1'b1;
      else begin
        attr_t a;
        a.line = bus.REQ_LINE;
        a.sz   = bus.REQ_SZ;
        a.sign = bus.REQ_SIGN;
        a.off  = int'(bus.REQ_OFFSET);
        aq.push_back(a);
        expc += a.line ? LW : 1;
      end
    end
    if (bus.CBUS_SDVAL) begin
      if (e0 == 0 || (dfull && !pop)) movf = 1'b1;
      else begin
        dq.push_back(bus.CBUS_SDDATA);
        expc--;
      end
    end
    if (pop) begin
      void'(dq.pop_front());
      if (plast) begin
        void'(aq.pop_front());
        hidx = 0;
      end else hidx++;
    end
  endtask

  // Outputs depend only on registered state, so a mid-cycle sample is stable.
  always @(negedge clk) begin
    chk("req_ready", 64'(bus.REQ_READY), 64'(aq.size() < OUTST));
    chk("dvalo", 64'(bus.DVALO), 64'(dq.size() != 0));
    chk("dlasto", 64'(bus.DLASTO), 64'(m_last()));
    chk("ddatao", 64'(bus.DDATAO), 64'(m_data()));
    chk("overflow", 64'(bus.OVERFLOW_R), 64'(movf));
  end

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
  endtask

  task automatic idle();
    bus.FLUSH       = 1'b0;
    bus.REQ_VALID   = 1'b0;
    bus.REQ_LINE    = 1'b0;
    bus.REQ_SZ      = 2'b00;
    bus.REQ_SIGN    = 1'b0;
    bus.REQ_OFFSET  = '0;
    bus.CBUS_SDVAL  = 1'b0;
    bus.CBUS_SDDATA = '0;
    bus.DREADY      = 1'b0;
  endtask

  task automatic req(logic line, logic [1:0] sz, logic sign, logic [1:0] off);
    bus.REQ_VALID  = 1'b1;
    bus.REQ_LINE   = line;
    bus.REQ_SZ     = sz;
    bus.REQ_SIGN   = sign;
    bus.REQ_OFFSET = off;
  endtask

  task automatic beat(logic [DW-1:0] d);
    bus.CBUS_SDVAL  = 1'b1;
    bus.CBUS_SDDATA = d;
  endtask

  task automatic do_flush();
    idle();
    bus.FLUSH = 1'b1;
    cycle();
    bus.FLUSH = 1'b0;
    chk("flush_ovf", 64'(bus.OVERFLOW_R), 64'd0);
    chk("flush_dval", 64'(bus.DVALO), 64'd0);
    chk("flush_ready", 64'(bus.REQ_READY), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    cycle();
    cycle();
    chk("rst_ready", 64'(bus.REQ_READY), 64'd1);
    chk("rst_dval", 64'(bus.DVALO), 64'd0);
    chk("rst_data", 64'(bus.DDATAO), 64'd0);
    chk("rst_last", 64'(bus.DLASTO), 64'd0);
    chk("rst_ovf", 64'(bus.OVERFLOW_R), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Word read, one beat
    req(1'b0, 2'b10, 1'b0, 2'd0);
    cycle();
    idle();
    chk("t1_noval", 64'(bus.DVALO), 64'd0);
    beat(32'h8899AABB);
    bus.DREADY = 1'b1;
    cycle();
    bus.CBUS_SDVAL = 1'b0;
    chk("t1_dval", 64'(bus.DVALO), 64'd1);
    chk("t1_data", 64'(bus.DDATAO), 64'h8899AABB);
    chk("t1_last", 64'(bus.DLASTO), 64'd1);
    chk("t1_ready", 64'(bus.REQ_READY), 64'd1);
    cycle();
    chk("t1_drain", 64'(bus.DVALO), 64'd0);

    // Byte signed and half unsigned extraction
    req(1'b0, 2'b00, 1'b1, 2'd3);
    cycle();
    idle();
    beat(32'h80FF0000);
    cycle();
    idle();
    chk("t2_byte", 64'(bus.DDATAO), 64'hFFFFFF80);
    bus.DREADY = 1'b1;
    req(1'b0, 2'b01, 1'b0, 2'd2);
    cycle();
    idle();
    beat(32'h80FF0000);
    cycle();
    idle();
    chk("t2_half", 64'(bus.DDATAO), 64'h000080FF);
    bus.DREADY = 1'b1;
    cycle();
    idle();

    // Line fill with a three-cycle stall
    req(1'b1, 2'b00, 1'b1, 2'd1);
    cycle();
    idle();
    for (int k = 1; k <= 3; k++) begin
      beat(DW'(k));
      cycle();
      chk("t3_hold", 64'(bus.DDATAO), 64'd1);
      chk("t3_nolast", 64'(bus.DLASTO), 64'd0);
    end
    beat(DW'(4));
    bus.DREADY = 1'b1;
    cycle();
    bus.CBUS_SDVAL = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      chk("t3_data", 64'(bus.DDATAO), 64'(k));
      chk("t3_last", 64'(bus.DLASTO), 64'(k == 4));
      cycle();
    end
    chk("t3_empty", 64'(bus.DVALO), 64'd0);
    chk("t3_ready", 64'(bus.REQ_READY), 64'd1);
    idle();

    // Attribute FIFO overflow
    req(1'b0, 2'b10, 1'b0, 2'd0);
    cycle();
    req(1'b1, 2'b10, 1'b0, 2'd0);
    cycle();
    chk("t4_full", 64'(bus.REQ_READY), 64'd0);
    chk("t4_ovf0", 64'(bus.OVERFLOW_R), 64'd0);
    cycle();
    chk("t4_reqovf", 64'(bus.OVERFLOW_R), 64'd1);
    do_flush();

    // Data FIFO overflow with two requests owning five beats
    req(1'b0, 2'b10, 1'b0, 2'd0);
    cycle();
    req(1'b1, 2'b10, 1'b0, 2'd0);
    cycle();
    idle();
    for (int k = 0; k < 5; k++) begin
      beat(DW'(k + 16));
      cycle();
      if (k == 3) chk("t4_fill", 64'(bus.OVERFLOW_R), 64'd0);
    end
    chk("t4_dataovf", 64'(bus.OVERFLOW_R), 64'd1);
    chk("t4_head", 64'(bus.DDATAO), 64'd16);
    do_flush();

    // Unowned beat, then flush discarding a same-cycle request
    beat(32'h1234);
    cycle();
    idle();
    chk("t5_noval", 64'(bus.DVALO), 64'd0);
    chk("t5_ovf", 64'(bus.OVERFLOW_R), 64'd1);
    do_flush();
    req(1'b0, 2'b10, 1'b0, 2'd0);
    beat(32'h5555);
    bus.FLUSH = 1'b1;
    cycle();
    idle();
    chk("t5_flush_ovf", 64'(bus.OVERFLOW_R), 64'd0);
    beat(32'h6666);
    cycle();
    idle();
    chk("t5_discarded", 64'(bus.OVERFLOW_R), 64'd1);
    do_flush();

    // Reset in the middle of a line fill
    req(1'b1, 2'b10, 1'b0, 2'd0);
    cycle();
    idle();
    bus.DREADY = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      beat(DW'(k + 32));
      cycle();
    end
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_dval", 64'(bus.DVALO), 64'd0);
    chk("t6_data", 64'(bus.DDATAO), 64'd0);
    chk("t6_last", 64'(bus.DLASTO), 64'd0);
    chk("t6_ready", 64'(bus.REQ_READY), 64'd1);
    cycle();
    rst_n = 1'b1;
    cycle();
    req(1'b0, 2'b10, 1'b0, 2'd0);
    cycle();
    idle();
    beat(32'h12345678);
    cycle();
    idle();
    chk("t6_data2", 64'(bus.DDATAO), 64'h12345678);
    chk("t6_last2", 64'(bus.DLASTO), 64'd1);
    bus.DREADY = 1'b1;
    cycle();
    chk("t6_done", 64'(bus.DVALO), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.REQ_VALID   = ($urandom_range(0, 99) < 30);
      bus.REQ_LINE    = ($urandom_range(0, 99) < 30);
      bus.REQ_SZ      = 2'($urandom_range(0, 3));
      bus.REQ_SIGN    = 1'($urandom_range(0, 1));
      bus.REQ_OFFSET  = 2'($urandom_range(0, 3));
      bus.CBUS_SDVAL  = (expc > 0) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 3);
      bus.CBUS_SDDATA = DW'($urandom);
      bus.DREADY      = ($urandom_range(0, 99) < 60);
      bus.FLUSH       = ($urandom_range(0, 199) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
